// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, byte-loaded instruction memory, next-PC select.
// Optional IF_ALIGN_CHECK_EN: misaligned branch/jump targets freeze fetch and raise o_addr_error.
module instruction_fetch #(
  parameter int PC_SIZE = 32,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int MEM_DEPTH = 64,
  parameter logic [INSTRUCTION_SIZE-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_enable,
  input  logic                        i_stall,
  input  logic [1:0]                  i_pc_src,
  input  logic [PC_SIZE-1:0]          i_branch_addr,
  input  logic [PC_SIZE-1:0]          i_jump_addr,
  input  logic [PC_SIZE-1:0]          i_jr_addr,
  input  logic                        i_wr_en,
  input  logic [7:0]                  i_wr_byte,
  input  logic                        i_clear,
  output logic [PC_SIZE-1:0]          o_pc,
  output logic [PC_SIZE-1:0]          o_next_seq_pc,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_halt,
  output logic                        o_mem_full,
  output logic                        o_mem_empty,
  output logic                        o_addr_error
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = AW + 3;
  localparam logic [PW-1:0] PTR_MAX = PW'(MEM_DEPTH * 4);

  logic [INSTRUCTION_SIZE-1:0] mem [MEM_DEPTH];
  logic [PW-1:0]               ptr;
  logic [PW-1:0]               ptr_inc;
  logic [1:0]                  lane;
  logic [PC_SIZE-1:0]          sel;
  logic [PC_SIZE-1:0]          tgt;
  logic                        upd;
  logic                        is_halt;
  logic                        bad;

  assign o_next_seq_pc = o_pc + PC_SIZE'(4);
  assign o_instruction = mem[o_pc[AW+1:2]];
  assign ptr_inc = ptr + PW'(1);
  assign lane = ~ptr[1:0];
  assign is_halt = (o_instruction == HALT_WORD);
  assign upd = i_enable && !i_stall && !o_halt
            && !o_addr_error && !i_wr_en;

  // Next-PC mux and target alignment handling
  always_comb begin
    sel = o_next_seq_pc;
    bad = 1'b0;
    unique case (i_pc_src)
      2'b00: sel = o_next_seq_pc;
      2'b01: sel = i_branch_addr;
      2'b10: sel = i_jump_addr;
      2'b11: sel = i_jr_addr;
      default: sel = o_next_seq_pc;
    endcase
`ifdef IF_ALIGN_CHECK_EN
    bad = (i_pc_src != 2'b00) && (sel[1:0] != 2'b00);
`endif
    tgt = sel & ~PC_SIZE'(3);
  end

  // Loader: big-endian byte writes, pointer and full/empty flags
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < MEM_DEPTH; k++)
        mem[k] <= '0;
      ptr         <= '0;
      o_mem_full  <= 1'b0;
      o_mem_empty <= 1'b1;
    end else if (i_clear) begin
      ptr         <= '0;
      o_mem_full  <= 1'b0;
      o_mem_empty <= 1'b1;
    end else if (i_wr_en && !o_mem_full) begin
      mem[ptr[PW-2:2]][{lane, 3'b000} +: 8] <= i_wr_byte;
      ptr         <= ptr_inc;
      o_mem_full  <= (ptr_inc == PTR_MAX);
      o_mem_empty <= 1'b0;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  logic addr_err;
  assign o_addr_error = addr_err;
`else
  assign o_addr_error = 1'b0;
`endif

  // PC register with halt and alignment-error freeze
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pc   <= '0;
      o_halt <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      addr_err <= 1'b0;
`endif
    end else if (i_clear) begin
      o_pc   <= '0;
      o_halt <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      addr_err <= 1'b0;
`endif
    end else if (upd) begin
      if (is_halt)
        o_halt <= 1'b1;
      else if (bad) begin
`ifdef IF_ALIGN_CHECK_EN
        addr_err <= 1'b1;
`endif
      end else
        o_pc <= tgt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
// Build with +define+IF_ALIGN_CHECK_EN to exercise the alignment check.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] br_addr;
  logic [31:0] j_addr;
  logic [31:0] jr_addr;
  logic        wr_en;
  logic [7:0]  wr_byte;
  logic        clr;
  logic [31:0] pc;
  logic [31:0] nseq;
  logic [31:0] instr;
  logic        halt;
  logic        full;
  logic        empty;
  logic        aerr;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_enable(enable),
    .i_stall(stall),
    .i_pc_src(pc_src),
    .i_branch_addr(br_addr),
    .i_jump_addr(j_addr),
    .i_jr_addr(jr_addr),
    .i_wr_en(wr_en),
    .i_wr_byte(wr_byte),
    .i_clear(clr),
    .o_pc(pc),
    .o_next_seq_pc(nseq),
    .o_instruction(instr),
    .o_halt(halt),
    .o_mem_full(full),
    .o_mem_empty(empty),
    .o_addr_error(aerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    wr_en = 1'b1;
    wr_byte = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic go(input logic [1:0] src);
    enable = 1'b1;
    pc_src = src;
    tick();
    enable = 1'b0;
    pc_src = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    stall = 1'b0;
    pc_src = 2'b00;
    br_addr = '0;
    j_addr = '0;
    jr_addr = '0;
    wr_en = 1'b0;
    wr_byte = '0;
    clr = 1'b0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_nseq", nseq, 32'h4);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    chk("rst_aerr", {31'b0, aerr}, 32'h0);
    chk("rst_empty", {31'b0, empty}, 32'h1);
    chk("rst_full", {31'b0, full}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    load(8'h00);
    chk("empty_after_1", {31'b0, empty}, 32'h0);
    load(8'h00);
    load(8'h00);
    load(8'h01);
    chk("word0", instr, 32'h0000_0001);
    load(8'hFF);
    load(8'hFF);
    load(8'hFF);
    load(8'hFF);

    enable = 1'b1;
    pc_src = 2'b00;
    tick();
    chk("seq_pc4", pc, 32'h4);
    chk("halt_word", instr, 32'hFFFF_FFFF);
    chk("halt_not_yet", {31'b0, halt}, 32'h0);
    tick();
    chk("halt_set", {31'b0, halt}, 32'h1);
    chk("halt_pc", pc, 32'h4);
    tick();
    enable = 1'b0;
    chk("halt_hold_pc", pc, 32'h4);
    chk("halt_hold_ins", instr, 32'hFFFF_FFFF);

    do_clear();
    chk("clr_pc", pc, 32'h0);
    chk("clr_halt", {31'b0, halt}, 32'h0);
    chk("clr_empty", {31'b0, empty}, 32'h1);
    chk("clr_mem_kept", instr, 32'h0000_0001);

    j_addr = 32'h8;
    go(2'b10);
    chk("jump_8", pc, 32'h8);
    enable = 1'b1;
    stall = 1'b1;
    tick();
    tick();
    chk("stall_hold", pc, 32'h8);
    stall = 1'b0;
    tick();
    enable = 1'b0;
    chk("stall_rel", pc, 32'hC);

    br_addr = 32'h40;
    go(2'b01);
    chk("branch", pc, 32'h40);
    j_addr = 32'h80;
    go(2'b10);
    chk("jump", pc, 32'h80);
    jr_addr = 32'hC0;
    go(2'b11);
    chk("jr", pc, 32'hC0);
    chk("jr_nseq", nseq, 32'hC4);

    j_addr = 32'hFFFF_FFFC;
    go(2'b10);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_nseq", nseq, 32'h0);
    go(2'b00);
    chk("wrap_seq", pc, 32'h0);

    j_addr = 32'h42;
    go(2'b10);
`ifdef IF_ALIGN_CHECK_EN
    chk("align_pc", pc, 32'h0);
    chk("align_err", {31'b0, aerr}, 32'h1);
    go(2'b00);
    chk("align_freeze", pc, 32'h0);
    do_clear();
    chk("align_clr", {31'b0, aerr}, 32'h0);
`else
    chk("align_pc", pc, 32'h40);
    chk("align_err", {31'b0, aerr}, 32'h0);
    do_clear();
`endif
    chk("pre_wr_pc", pc, 32'h0);

    enable = 1'b1;
    pc_src = 2'b00;
    load(8'hAA);
    enable = 1'b0;
    chk("wr_en_pc", pc, 32'h0);
    chk("wr_en_byte", instr, 32'hAA00_0001);

    do_clear();
    for (int i = 0; i < 255; i++)
      load(8'(i));
    chk("full_255", {31'b0, full}, 32'h0);
    load(8'hFF);
    chk("full_256", {31'b0, full}, 32'h1);
    chk("fill_w0", instr, 32'h0001_0203);
    load(8'hEE);
    chk("drop_257", instr, 32'h0001_0203);
    chk("drop_full", {31'b0, full}, 32'h1);
    j_addr = 32'h1FC;
    go(2'b10);
    chk("fill_w63_wrap", instr, 32'hFCFD_FEFF);
    do_clear();
    chk("clr2_empty", {31'b0, empty}, 32'h1);
    chk("clr2_full", {31'b0, full}, 32'h0);
    chk("clr2_mem", instr, 32'h0001_0203);

    j_addr = 32'h4;
    go(2'b10);
    chk("pre_halt", instr, 32'h0405_0607);
    load(8'h11);
    chk("pre_rst_pc", pc, 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_halt", {31'b0, halt}, 32'h0);
    chk("async_empty", {31'b0, empty}, 32'h1);
    chk("async_mem", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the 5-stage pipeline, directly upstream of the IF/ID latch. Holds the PC register, a byte-loadable instruction memory filled by the debug loader, next-PC selection (sequential / branch / jump / jump-register), stall hold and halt detection. Drives the sequential next PC and the fetched instruction that the IF/ID latch captures.

## Interface
- PC_SIZE, 32, PC and address width
- INSTRUCTION_SIZE, 32, instruction width
- MEM_DEPTH, 64, instruction memory depth in words (power of two)
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  pipeline step enable from the debug unit
- i_stall  in  1  hazard stall; hold PC
- i_pc_src  in  2  00 seq, 01 branch, 10 jump, 11 jump-register
- i_branch_addr, i_jump_addr, i_jr_addr  in  PC_SIZE each  target addresses from ID
- i_wr_en  in  1  loader byte write strobe
- i_wr_byte  in  8  loader byte
- i_clear  in  1  synchronous clear of loader pointer and halt/error flags
- o_pc  out  PC_SIZE  current PC
- o_next_seq_pc  out  PC_SIZE  o_pc + 4
- o_instruction  out  INSTRUCTION_SIZE  word at mem[o_pc[log2(MEM_DEPTH)+1:2]]
- o_halt  out  1  sticky, halt word reached
- o_mem_full  out  1  loader pointer reached MEM_DEPTH*4 bytes
- o_mem_empty  out  1  no bytes loaded
- o_addr_error  out  1  sticky misaligned target (see Configuration)

## Operation
- Reset (i_reset_n low, async): PC = 0, memory all zero, write pointer = 0, o_halt = 0, o_addr_error = 0, o_mem_empty = 1, o_mem_full = 0. Consequently o_instruction = 0 and o_next_seq_pc = 4.
- Loader: on i_wr_en with !o_mem_full, the byte goes to byte address = pointer and the pointer increments. Words are big-endian: byte 4k is bits [31:24] of word k. Writes with o_mem_full = 1 are dropped and the pointer holds.
- Fetch read is combinational from PC. The word index wraps modulo MEM_DEPTH, and PC[1:0] are ignored for reads.
- A PC update occurs when i_enable && !i_stall && !o_halt && !o_addr_error && !i_wr_en.
  - If o_instruction == HALT_WORD: PC holds and o_halt is set.
  - Otherwise PC <= the value selected by i_pc_src: o_next_seq_pc, i_branch_addr, i_jump_addr or i_jr_addr.
- o_halt and o_addr_error are cleared only by reset or i_clear.
- i_clear (sync): pointer = 0, PC = 0, flags = 0. Memory contents are kept. i_clear takes priority over a write and over a PC update in the same cycle.
- Simultaneous i_wr_en and i_enable: the write is performed and the PC does not advance.
- PC arithmetic is modulo 2^PC_SIZE; 0xFFFF_FFFC + 4 wraps to 0.

## Timing
- Zero-cycle fetch: o_instruction and o_next_seq_pc follow o_pc combinationally.
- PC changes one edge after the qualifying cycle.
- o_halt rises on the edge at which HALT_WORD was presented with an update enabled. The halt word is still at o_instruction afterwards; IF/ID is expected to be disabled by the debug unit.
- Written byte visible at o_instruction the cycle after the write edge.
- o_mem_full / o_mem_empty are registered and change on the write edge.

## Configuration
- IF_ALIGN_CHECK_EN defined: a selected non-sequential target with bits [1:0] != 0 blocks the PC update, and o_addr_error is set on that edge (sticky; freezes fetch like halt).
- Not defined: target bits [1:0] are forced to 00 on load, and o_addr_error is tied 0.

## Test plan
- Reset then load 8 bytes 00 00 00 01, FF FF FF FF; enable 3 cycles with pc_src = 00:
  - o_pc goes 0 -> 4 and holds.
  - o_halt = 1 after the second edge.
  - o_instruction = 0xFFFFFFFF.
- Stall: enable = 1, stall = 1 for 2 cycles at PC 8 -> PC stays 8. On stall release -> PC 12.
- Branch/jump/jr: pc_src 01, 10, 11 with targets 0x40, 0x80, 0xC0 -> PC equals each target after one edge.
- Fill: 256 writes -> o_mem_full = 1. Write 257 is dropped (word 0 unchanged). i_clear -> o_mem_empty = 1, memory kept.
- Simultaneous i_wr_en and i_enable -> byte written, PC unchanged. Async i_reset_n low mid-run -> PC = 0 immediately, flags 0.
- With IF_ALIGN_CHECK_EN: jump to 0x42 -> PC holds, o_addr_error = 1. Without the macro: PC = 0x40.
